// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP/Ethernet TX FCS path.
// Reflected CRC-32 held MSB-first so FCS bits read out in wire order.
package udp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PAD,
    FCS
  } state_t;

  localparam int UDP_MIN_PAYLOAD = 60;
  localparam int UDP_FCS_BYTES   = 4;

  localparam logic [31:0] UDP_CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] UDP_CRC_POLY = 32'h04C1_1DB7;

  // One byte of CRC-32, data bits fed LSB first
  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[31] ^ d[i];
      r  = {r[30:0], 1'b0} ^ (fb ? UDP_CRC_POLY : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/udp_crc.sv
// Byte-wide Ethernet CRC-32 engine.
// Synchronous clear has priority over enable.
module udp_crc
  import udp_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_sreset,
  input  logic        i_enable,
  input  logic [7:0]  i_dat,
  output logic [31:0] o_crc
);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_crc <= UDP_CRC_INIT;
    end else if (i_sreset) begin
      o_crc <= UDP_CRC_INIT;
    end else if (i_enable) begin
      o_crc <= crc_step(o_crc, i_dat);
    end
  end

endmodule

// File: rtl/udp_fcs_tx.sv
// TX frame forwarder appending the Ethernet FCS, LSB first.
// Define UDP_FCS_PAD_EN to zero-pad short frames to 60 bytes.
module udp_fcs_tx
  import udp_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_flush,
  input  logic [7:0]  s_dat,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_dat,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        o_busy,
  output logic [15:0] o_frm_cnt
);

  state_t      st, st_n;
  logic [5:0]  cnt, cnt_n, cnt_inc;
  logic [1:0]  idx, idx_n;
  logic [7:0]  dat_n;
  logic        vld_n, last_n;
  logic [15:0] frm_n;
  logic        ld, acc, pad_go;
  logic        crc_en, crc_clr;
  logic [7:0]  crc_d;
  logic [31:0] crc, fcs;

  assign ld      = !m_valid || m_ready;
  assign s_ready = (st == IDLE || st == DATA) && ld;
  assign acc     = s_valid && s_ready;
  assign o_busy  = (st != IDLE);
  assign cnt_inc = (cnt == 6'd63) ? cnt : cnt + 6'd1;

`ifdef UDP_FCS_PAD_EN
  assign pad_go = (cnt_inc < 6'(UDP_MIN_PAYLOAD));
`else
  assign pad_go = 1'b0;
`endif

  // Wire-order FCS: complemented, bit-reversed CRC
  always_comb begin
    fcs = '0;
    for (int i = 0; i < 32; i++) begin
      fcs[i] = ~crc[31-i];
    end
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    idx_n   = idx;
    dat_n   = m_dat;
    vld_n   = m_valid;
    last_n  = m_last;
    frm_n   = o_frm_cnt;
    crc_en  = 1'b0;
    crc_clr = 1'b0;
    crc_d   = s_dat;
    if (ld) begin
      vld_n  = 1'b0;
      last_n = 1'b0;
    end
    unique case (st)
      IDLE, DATA: begin
        if (acc) begin
          dat_n  = s_dat;
          vld_n  = 1'b1;
          crc_en = 1'b1;
          cnt_n  = cnt_inc;
          if (s_last) begin
            st_n = pad_go ? PAD : FCS;
          end else begin
            st_n = DATA;
          end
        end
      end
`ifdef UDP_FCS_PAD_EN
      PAD: begin
        if (ld) begin
          dat_n  = 8'h00;
          vld_n  = 1'b1;
          crc_en = 1'b1;
          crc_d  = 8'h00;
          cnt_n  = cnt_inc;
          if (cnt_inc >= 6'(UDP_MIN_PAYLOAD)) begin
            st_n = FCS;
          end
        end
      end
`endif
      FCS: begin
        if (ld) begin
          dat_n = fcs[{idx, 3'b000} +: 8];
          vld_n = 1'b1;
          idx_n = idx + 2'd1;
          if (idx == 2'(UDP_FCS_BYTES - 1)) begin
            last_n  = 1'b1;
            crc_clr = 1'b1;
            frm_n   = o_frm_cnt + 16'd1;
            cnt_n   = '0;
            idx_n   = '0;
            st_n    = IDLE;
          end
        end
      end
      default: st_n = IDLE;
    endcase
    if (i_flush) begin
      st_n    = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
      dat_n   = m_dat;
      vld_n   = 1'b0;
      last_n  = 1'b0;
      frm_n   = o_frm_cnt;
      crc_en  = 1'b0;
      crc_clr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st        <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      m_dat     <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      o_frm_cnt <= '0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      m_dat     <= dat_n;
      m_valid   <= vld_n;
      m_last    <= last_n;
      o_frm_cnt <= frm_n;
    end
  end

  udp_crc u_crc (
    .clk      (clk),
    .nrst     (nrst),
    .i_sreset (crc_clr),
    .i_enable (crc_en),
    .i_dat    (crc_d),
    .o_crc    (crc)
  );

endmodule

// File: tb/tb_udp_fcs_tx.sv
// Directed bench for udp_fcs_tx with a reflected CRC-32 reference.
// Honours UDP_FCS_PAD_EN when expected frames are built.
module tb_udp_fcs_tx;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_flush = 1'b0;
  logic [7:0]  s_dat = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  m_dat;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic        o_busy;
  logic [15:0] o_frm_cnt;

  logic [8:0] tx[$];
  logic [8:0] obs[$];
  logic [8:0] exp_q[$];
  logic [7:0] ascii[$] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                           8'h36, 8'h37, 8'h38, 8'h39};
  int errors = 0;
  int checks = 0;
  int stall_err = 0;

  always #5 clk = ~clk;

  udp_fcs_tx dut (
    .clk       (clk),
    .nrst      (nrst),
    .i_flush   (i_flush),
    .s_dat     (s_dat),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_dat     (m_dat),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .o_busy    (o_busy),
    .o_frm_cnt (o_frm_cnt)
  );

  function automatic logic [31:0] ref_fcs(input logic [7:0] f[$]);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (f[i]) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void add_frame(input logic [7:0] b[$]);
    logic [7:0]  f[$];
    logic [31:0] c;
    f = b;
`ifdef UDP_FCS_PAD_EN
    while (f.size() < 60) f.push_back(8'h00);
`endif
    foreach (b[i]) tx.push_back({(i == b.size() - 1), b[i]});
    foreach (f[i]) exp_q.push_back({1'b0, f[i]});
    c = ref_fcs(f);
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), c[8*k +: 8]});
  endfunction

  task automatic run_frame(input int bp, input int flush_at, input int nfr,
                           input int stop_after, output bit to);
    int i, cyc, nl;
    bit done, stalled;
    logic [7:0] held;
    i = 0; cyc = 0; nl = 0; done = 0; stalled = 0; held = 0; to = 0;
    obs.delete();
    while (!done) begin
      @(negedge clk);
      m_ready = (bp == 0) ? 1'b1 : ($urandom_range(99) >= bp);
      i_flush = (i == flush_at);
      s_valid = !i_flush && (i < tx.size());
      s_dat   = (i < tx.size()) ? tx[i][7:0] : 8'h00;
      s_last  = (i < tx.size()) ? tx[i][8] : 1'b0;
      #1;
      if (stop_after >= 0 && obs.size() == stop_after) break;
      if (stalled && m_dat !== held) stall_err++;
      stalled = m_valid && !m_ready;
      held = m_dat;
      if (m_valid && m_ready) begin
        obs.push_back({m_last, m_dat});
        if (m_last) nl++;
      end
      if (s_valid && s_ready) i++;
      cyc++;
      to = (cyc > 3000);
      done = i_flush || (nl == nfr) || to;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b1;
    if (i_flush) begin
      @(posedge clk);
      #1 i_flush = 1'b0;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #1;
    checks++; if (m_dat !== 8'h00) begin errors++; $display("FAIL rst_m_dat got=%h exp=00", m_dat); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
    checks++; if (o_frm_cnt !== 16'd0) begin errors++; $display("FAIL rst_frm_cnt got=%0d exp=0", o_frm_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_ascii();
    bit to;
    int bad;
    logic [8:0] hard[4] = '{9'h026, 9'h039, 9'h0F4, 9'h1CB};
    tx.delete(); exp_q.delete();
    add_frame(ascii);
    run_frame(0, -1, 1, -1, to);
    checks++; if (to) begin errors++; $display("FAIL ascii_timeout got=1 exp=0"); end
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL ascii_len got=%0d exp=%0d", obs.size(), exp_q.size()); end
    bad = 0;
    foreach (exp_q[i]) if (i >= obs.size() || obs[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ascii_data got=%0d bad bytes exp=0", bad); end
`ifndef UDP_FCS_PAD_EN
    bad = 0;
    for (int k = 0; k < 4; k++) if (obs.size() < 13 || obs[9+k] !== hard[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ascii_fcs_const got=%0d bad bytes exp=0", bad); end
`else
    checks++; if (obs.size() != 64) begin errors++; $display("FAIL pad_len got=%0d exp=64", obs.size()); end
`endif
    @(negedge clk);
    checks++; if (o_frm_cnt !== 16'd1) begin errors++; $display("FAIL ascii_frm_cnt got=%0d exp=1", o_frm_cnt); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ascii_busy got=%b exp=0", o_busy); end
  endtask

  task automatic test_backpressure();
    bit to;
    int bad;
    logic [7:0] b[$];
    tx.delete(); exp_q.delete();
    for (int i = 0; i < 100; i++) b.push_back(8'(i * 37 + 5));
    add_frame(b);
    stall_err = 0;
    run_frame(50, -1, 1, -1, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout got=1 exp=0"); end
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got=%0d exp=%0d", obs.size(), exp_q.size()); end
    bad = 0;
    foreach (exp_q[i]) if (i >= obs.size() || obs[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_data got=%0d bad bytes exp=0", bad); end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stall_hold got=%0d changes exp=0", stall_err); end
    @(negedge clk);
    checks++; if (o_frm_cnt !== 16'd2) begin errors++; $display("FAIL bp_frm_cnt got=%0d exp=2", o_frm_cnt); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int bad;
    logic [7:0] b1[$];
    logic [7:0] b2[$];
    tx.delete(); exp_q.delete();
    b1.push_back(8'hA5);
    for (int i = 0; i < 70; i++) b2.push_back(8'(i) ^ 8'h5A);
    add_frame(b1);
    add_frame(b2);
    run_frame(0, -1, 2, -1, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout got=1 exp=0"); end
    checks++; if (obs.size() != exp_q.size()) begin errors++; $display("FAIL b2b_len got=%0d exp=%0d", obs.size(), exp_q.size()); end
    bad = 0;
    foreach (exp_q[i]) if (i >= obs.size() || obs[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data got=%0d bad bytes exp=0", bad); end
    @(negedge clk);
    checks++; if (o_frm_cnt !== 16'd4) begin errors++; $display("FAIL b2b_frm_cnt got=%0d exp=4", o_frm_cnt); end
  endtask

  task automatic test_flush();
    bit to;
    int bad, nl;
    logic [7:0] b[$];
    tx.delete(); exp_q.delete();
    for (int i = 0; i < 20; i++) b.push_back(8'(8'hC0 + i));
    add_frame(b);
    run_frame(0, 10, 1, -1, to);
    nl = 0;
    foreach (obs[i]) if (obs[i][8]) nl++;
    checks++; if (nl != 0) begin errors++; $display("FAIL flush_no_last got=%0d exp=0", nl); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid got=%b exp=0", m_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", o_busy); end
    checks++; if (o_frm_cnt !== 16'd4) begin errors++; $display("FAIL flush_frm_cnt got=%0d exp=4", o_frm_cnt); end
    tx.delete(); exp_q.delete();
    add_frame(ascii);
    run_frame(0, -1, 1, -1, to);
    checks++; if (to) begin errors++; $display("FAIL flush_next_timeout got=1 exp=0"); end
    bad = (obs.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i >= obs.size() || obs[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL flush_next_data got=%0d bad exp=0", bad); end
    @(negedge clk);
    checks++; if (o_frm_cnt !== 16'd5) begin errors++; $display("FAIL flush_next_frm_cnt got=%0d exp=5", o_frm_cnt); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int bad;
    logic [7:0] want;
    tx.delete(); exp_q.delete();
    add_frame(ascii);
    want = exp_q[exp_q.size() - 2][7:0];
    run_frame(0, -1, 1, exp_q.size() - 2, to);
    checks++; if (m_dat !== want || m_valid !== 1'b1) begin errors++; $display("FAIL mid_fcs2 got=%h/%b exp=%h/1", m_dat, m_valid, want); end
    nrst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_dat !== 8'h00) begin errors++; $display("FAIL mid_rst_m_dat got=%h exp=00", m_dat); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL mid_rst_m_last got=%b exp=0", m_last); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", o_busy); end
    checks++; if (o_frm_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_frm_cnt got=%0d exp=0", o_frm_cnt); end
    @(negedge clk);
    nrst = 1'b1;
    tx.delete(); exp_q.delete();
    add_frame(ascii);
    run_frame(0, -1, 1, -1, to);
    checks++; if (to) begin errors++; $display("FAIL mid_next_timeout got=1 exp=0"); end
    bad = (obs.size() != exp_q.size()) ? 1 : 0;
    foreach (exp_q[i]) if (i >= obs.size() || obs[i] !== exp_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_next_data got=%0d bad exp=0", bad); end
    @(negedge clk);
    checks++; if (o_frm_cnt !== 16'd1) begin errors++; $display("FAIL mid_next_frm_cnt got=%0d exp=1", o_frm_cnt); end
  endtask

  initial begin
    test_reset();
    test_ascii();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
